// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 keystream XOR block.
//   DW_DEFAULT         default data/key word width
//   KEY_DEPTH_DEFAULT  default keystream FIFO depth
//   occ_state_e        keystream FIFO occupancy state encoding
package rc4_pkg;

  localparam int unsigned DW_DEFAULT        = 32;
  localparam int unsigned KEY_DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    OccEmpty   = 2'd0,
    OccPartial = 2'd1,
    OccFull    = 2'd2
  } occ_state_e;

endpackage

// File: rtl/rc4_key_fifo.sv
// Keystream FIFO: storage array, wrapping read/write pointers, occupancy counter and
// occupancy state. Full/empty come only from the registered occupancy, never from
// pointer comparison.
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   flush          synchronous clear of pointers and occupancy (wins over push/pop)
//   push/push_data write one key at the write pointer
//   pop            retire the head key
//   head           head key, read combinationally
//   level          current occupancy
//   full/empty     registered-occupancy flags
module rc4_key_fifo
  import rc4_pkg::*;
#(
  parameter int unsigned Depth = KEY_DEPTH_DEFAULT,
  parameter int unsigned Width = DW_DEFAULT,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned LvlW = PtrW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] head,
  output logic [LvlW-1:0]  level,
  output logic             full,
  output logic             empty
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [LvlW-1:0]  count_q, count_d;
  occ_state_e       state_q, state_d;
  logic             push_ok, pop_ok;

  // Never overrun or underrun, even if the caller misqualifies a request.
  assign push_ok = push && (state_q != OccFull) && !flush;
  assign pop_ok  = pop && (state_q != OccEmpty) && !flush;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      // Depth is a power of two, so natural pointer overflow is the modulo wrap.
      if (push_ok) wptr_d = wptr_q + 1'b1;
      if (pop_ok)  rptr_d = rptr_q + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Occupancy state follows the next occupancy so it always matches count_q.
  always_comb begin
    state_d = OccPartial;
    if (count_d == '0) begin
      state_d = OccEmpty;
    end else if (count_d == LvlW'(Depth)) begin
      state_d = OccFull;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      state_q <= OccEmpty;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  // Storage needs no reset: entries are only read when occupancy says they are valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q] <= push_data;
    end
  end

  assign head  = mem_q[rptr_q];
  assign level = count_q;
  assign full  = (state_q == OccFull);
  assign empty = (state_q == OccEmpty);

endmodule

// File: rtl/rc4_keystream_xor.sv
// Buffers RC4 keystream words and XORs one into each accepted data word (encrypt and
// decrypt are the same operation). Result is registered: one-cycle latency, full
// throughput, and the output holds under backpressure.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   flush                 synchronous keystream resync; blocks all handshakes that cycle
//   bypass                per word: pass data unmodified and consume no key
//   key_valid/key_in/key_ready     keystream input stream
//   data_valid/data_in/data_ready  data input stream
//   out_valid/out_data/out_ready   result stream
//   key_level             keystream FIFO occupancy
//   word_count            keyed words processed (only with RC4_XOR_WORD_COUNT_EN)
// Optional feature macro: RC4_XOR_WORD_COUNT_EN
module rc4_keystream_xor
  import rc4_pkg::*;
#(
  parameter int unsigned KEY_DEPTH = KEY_DEPTH_DEFAULT,
  parameter int unsigned DW        = DW_DEFAULT,
  localparam int unsigned LvlW     = $clog2(KEY_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            bypass,
  input  logic            key_valid,
  input  logic [DW-1:0]   key_in,
  output logic            key_ready,
  input  logic            data_valid,
  input  logic [DW-1:0]   data_in,
  output logic            data_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  input  logic            out_ready,
`ifdef RC4_XOR_WORD_COUNT_EN
  output logic [15:0]     word_count,
`endif
  output logic [LvlW-1:0] key_level
);

  logic          active_q;
  logic          fifo_full, fifo_empty;
  logic [DW-1:0] head_key;
  logic          key_push, key_pop, data_hs;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;

  // Holds key_ready low until the first clock edge after reset deasserts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_q <= 1'b0;
    end else begin
      active_q <= 1'b1;
    end
  end

  assign key_ready  = active_q && !fifo_full && !flush;
  assign data_ready = !flush && (bypass || !fifo_empty) && (!out_valid_q || out_ready);
  assign key_push   = key_valid && key_ready;
  assign data_hs    = data_valid && data_ready;
  assign key_pop    = data_hs && !bypass;

  rc4_key_fifo #(
    .Depth (KEY_DEPTH),
    .Width (DW)
  ) u_key_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (key_push),
    .push_data (key_in),
    .pop       (key_pop),
    .head      (head_key),
    .level     (key_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (data_hs) begin
      out_valid_d = 1'b1;
      out_data_d  = bypass ? data_in : (data_in ^ head_key);
    end else if (out_ready) begin
      // Drained with nothing new: drop valid, keep the last word visible.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef RC4_XOR_WORD_COUNT_EN
  logic [15:0] wcount_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wcount_q <= '0;
    end else if (flush) begin
      wcount_q <= '0;
    end else if (key_pop) begin
      wcount_q <= wcount_q + 16'd1;
    end
  end

  assign word_count = wcount_q;
`endif

endmodule
